// File: rtl/nbr_window_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : nbr_window_gen_if
// Description : Pixel stream input and 3x3 window / mux-select output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface nbr_window_gen_if;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pix_sof;
    logic       pix_ready;
    logic [7:0] nb1;
    logic [7:0] nb2;
    logic [7:0] nb3;
    logic [7:0] nb4;
    logic [7:0] nb5;
    logic [7:0] nb6;
    logic [7:0] nb7;
    logic [7:0] nb8;
    logic [7:0] center;
    logic [2:0] sel_mux;
    logic       sel_valid;
    logic       sel_last;

    // Pixel source side; it also observes the window outputs
    modport master (
        output pix_in, pix_valid, pix_sof,
        input  pix_ready,
        input  nb1, nb2, nb3, nb4, nb5, nb6, nb7, nb8, center,
        input  sel_mux, sel_valid, sel_last
    );

    // Window generator side
    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output pix_ready,
        output nb1, nb2, nb3, nb4, nb5, nb6, nb7, nb8, center,
        output sel_mux, sel_valid, sel_last
    );
endinterface
`default_nettype wire

// File: rtl/nbr_window_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : nbr_window_gen
// Description : Two-line-buffer 3x3 window former that walks mux select 0..7.
// Revision    : 1.0 - initial release
// ============================================================================
module nbr_window_gen #(
    parameter int IMG_WIDTH = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    nbr_window_gen_if.slave   bus
);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;

    logic [COL_W-1:0] r_col;
    logic [1:0]       r_row;
    logic [7:0]       r_lb0 [IMG_WIDTH];
    logic [7:0]       r_lb1 [IMG_WIDTH];

    logic [7:0]       r_top_c0, r_top_c1;
    logic [7:0]       r_mid_c0, r_mid_c1;
    logic [7:0]       r_bot_c0, r_bot_c1;

    logic [7:0]       r_nb1, r_nb2, r_nb3, r_nb4;
    logic [7:0]       r_nb5, r_nb6, r_nb7, r_nb8;
    logic [7:0]       r_center;

    logic             w_accept;
    logic [COL_W-1:0] w_col_cur;
    logic [1:0]       w_row_cur;
    logic [1:0]       w_row_inc;
    logic [7:0]       w_top;
    logic [7:0]       w_mid;
    logic             w_win;

    // A start-of-frame pixel is positioned at row 0, col 0 whatever the counters say
    assign w_accept  = bus.pix_valid && (r_state == S_IDLE);
    assign w_col_cur = bus.pix_sof ? '0 : r_col;
    assign w_row_cur = bus.pix_sof ? 2'd0 : r_row;
    assign w_row_inc = (w_row_cur == 2'd2) ? 2'd2 : w_row_cur + 2'd1;
    assign w_top     = r_lb1[w_col_cur];
    assign w_mid     = r_lb0[w_col_cur];
    assign w_win     = w_accept && (w_row_cur == 2'd2) && (w_col_cur >= c_col_two);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: begin
                if (w_win) begin
                    w_state_nxt = S_SCAN;
                    w_sel_nxt   = 3'd0;
                end
            end
            S_SCAN: begin
                if (r_sel == 3'd7) begin
                    w_state_nxt = S_IDLE;
                    w_sel_nxt   = 3'd0;
                end else begin
                    w_sel_nxt   = r_sel + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= 2'd0;
        end else if (w_accept) begin
            if (w_col_cur == c_col_last) begin
                r_col <= '0;
                r_row <= w_row_inc;
            end else begin
                r_col <= w_col_cur + COL_W'(1);
                r_row <= w_row_cur;
            end
        end
    end

    // Line buffers carry no reset: row = 0 after reset keeps stale data out of any window
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col_cur] <= r_lb0[w_col_cur];
            r_lb0[w_col_cur] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top_c0 <= 8'd0;
            r_top_c1 <= 8'd0;
            r_mid_c0 <= 8'd0;
            r_mid_c1 <= 8'd0;
            r_bot_c0 <= 8'd0;
            r_bot_c1 <= 8'd0;
        end else if (w_accept) begin
            r_top_c0 <= r_top_c1;
            r_top_c1 <= w_top;
            r_mid_c0 <= r_mid_c1;
            r_mid_c1 <= w_mid;
            r_bot_c0 <= r_bot_c1;
            r_bot_c1 <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nb1    <= 8'd0;
            r_nb2    <= 8'd0;
            r_nb3    <= 8'd0;
            r_nb4    <= 8'd0;
            r_nb5    <= 8'd0;
            r_nb6    <= 8'd0;
            r_nb7    <= 8'd0;
            r_nb8    <= 8'd0;
            r_center <= 8'd0;
        end else if (w_win) begin
            r_nb1    <= r_top_c0;
            r_nb2    <= r_top_c1;
            r_nb3    <= w_top;
            r_nb4    <= r_mid_c0;
            r_center <= r_mid_c1;
            r_nb5    <= w_mid;
            r_nb6    <= r_bot_c0;
            r_nb7    <= r_bot_c1;
            r_nb8    <= bus.pix_in;
        end
    end

    assign bus.pix_ready = (r_state == S_IDLE);
    assign bus.sel_valid = (r_state == S_SCAN);
    assign bus.sel_last  = (r_state == S_SCAN) && (r_sel == 3'd7);
    assign bus.sel_mux   = r_sel;
    assign bus.nb1       = r_nb1;
    assign bus.nb2       = r_nb2;
    assign bus.nb3       = r_nb3;
    assign bus.nb4       = r_nb4;
    assign bus.nb5       = r_nb5;
    assign bus.nb6       = r_nb6;
    assign bus.nb7       = r_nb7;
    assign bus.nb8       = r_nb8;
    assign bus.center    = r_center;
endmodule
`default_nettype wire

// File: tb/tb_nbr_window_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_nbr_window_gen
// Description : Directed bench for nbr_window_gen on a 4-pixel-wide image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbr_window_gen;
    localparam int IMG_WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   nwin  = 0;
    logic [71:0] w_obs;

    nbr_window_gen_if u_if ();

    nbr_window_gen #(.IMG_WIDTH(IMG_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    assign w_obs = {u_if.nb1, u_if.nb2, u_if.nb3, u_if.nb4, u_if.nb5,
                    u_if.nb6, u_if.nb7, u_if.nb8, u_if.center};

    // Expected {nb1..nb8, center} when the pixel at frame (r, c) completes a window
    function automatic logic [71:0] win_of(input logic [7:0] base, input int r, input int c);
        logic [7:0] v [3][3];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v[dr][dc] = base + 8'((r - 2 + dr) * 16 + (c - 2 + dc));
        return {v[0][0], v[0][1], v[0][2], v[1][0], v[1][2],
                v[2][0], v[2][1], v[2][2], v[1][1]};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge. mode 0 = border, 1 = window, 2 = no check
    task automatic send(input logic [7:0] p, input bit sof, input int mode, input logic [71:0] exp);
        int n = 0;
        u_if.pix_in    = p;
        u_if.pix_sof   = sof;
        u_if.pix_valid = 1'b1;
        while (u_if.pix_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 72'(u_if.pix_ready), 72'(1));
        @(posedge clk);
        @(negedge clk);
        u_if.pix_sof = 1'b0;
        if (u_if.sel_valid === 1'b1) nwin++;
        if (mode == 1) begin
            for (int i = 0; i < 8; i++) begin
                chk("scan_valid", 72'(u_if.sel_valid), 72'(1));
                chk("scan_sel",   72'(u_if.sel_mux),   72'(i));
                chk("scan_last",  72'(u_if.sel_last),  72'(i == 7));
                chk("scan_ready", 72'(u_if.pix_ready), 72'(0));
                chk("scan_win",   w_obs, exp);
                u_if.pix_in = 8'(8'hE0 + i);
                @(negedge clk);
            end
            chk("scan_end_ready", 72'(u_if.pix_ready), 72'(1));
            chk("scan_end_valid", 72'(u_if.sel_valid), 72'(0));
        end else if (mode == 0) begin
            chk("border_valid", 72'(u_if.sel_valid), 72'(0));
            chk("border_ready", 72'(u_if.pix_ready), 72'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [71:0] exp;
        rst            = 1'b1;
        u_if.pix_in    = 8'd0;
        u_if.pix_valid = 1'b0;
        u_if.pix_sof   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  72'(u_if.pix_ready), 72'(1));
        chk("rst_valid",  72'(u_if.sel_valid), 72'(0));
        chk("rst_sel",    72'(u_if.sel_mux),   72'(0));
        chk("rst_last",   72'(u_if.sel_last),  72'(0));
        chk("rst_window", w_obs, 72'(0));
        rst = 1'b0;

        // Frame A: full 4x4 ramp, junk on pix_in during every scan
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp = win_of(8'h00, r, c);
                if (r == 2 && c == 2) exp = 72'h00_01_02_10_12_20_21_22_11;
                send(8'(r * 16 + c), (r == 0 && c == 0), (r >= 2 && c >= 2) ? 1 : 0, exp);
            end
        end
        chk("frame_windows", 72'(nwin), 72'(4));
        u_if.pix_valid = 1'b0;
        @(negedge clk);

        // Frame B: reset in the middle of the first scan
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < ((r == 2) ? 3 : 4); c++)
                send(8'(8'h40 + r * 16 + c), (r == 0 && c == 0), (r == 2 && c == 2) ? 2 : 0, 72'(0));
        u_if.pix_valid = 1'b0;
        chk("b_scan_start", 72'(u_if.sel_mux), 72'(0));
        repeat (3) @(negedge clk);
        chk("b_scan_sel3",  72'(u_if.sel_mux), 72'(3));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid",  72'(u_if.sel_valid), 72'(0));
        chk("midrst_ready",  72'(u_if.pix_ready), 72'(1));
        chk("midrst_sel",    72'(u_if.sel_mux),   72'(0));
        chk("midrst_window", w_obs, 72'(0));
        rst = 1'b0;
        @(negedge clk);

        // Re-feed frame B without sof: only (2,2) forms a window
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < ((r == 2) ? 3 : 4); c++)
                send(8'(8'h40 + r * 16 + c), 1'b0, (r == 2 && c == 2) ? 1 : 0, win_of(8'h40, r, c));

        // Frame C starts mid-frame; without the sof this pixel would complete a window
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send(8'(8'hA0 + r * 16 + c), (r == 0 && c == 0), (r == 2 && c >= 2) ? 1 : 0,
                     win_of(8'hA0, r, c));
        chk("total_windows", 72'(nwin), 72'(8));
        u_if.pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_idle", 72'(u_if.sel_valid), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nbr_window_gen.md
# nbr_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the 8:1 pixel select mux. It buffers two image lines of 8-bit grey pixels and forms the 3x3 window around each interior pixel. For every complete window it holds the eight neighbours and the centre on registered outputs, then walks the mux select through 0..7, one neighbour per cycle. Outputs feed the mux data inputs and select directly.

## Interface
- IMG_WIDTH, 256: pixels per image line (>= 3); column counter width is $clog2(IMG_WIDTH).
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  8  incoming pixel, raster order
- pix_valid  in  1  pix_in valid this cycle
- pix_sof  in  1  qualifies pix_in as first pixel of a frame (row 0, col 0)
- pix_ready  out  1  block accepts pixel when pix_valid && pix_ready
- nb1..nb8  out  8 each  neighbours NW, N, NE, W, E, SW, S, SE; connect to mux inputs 1..8
- center  out  8  window centre pixel
- sel_mux  out  3  neighbour select to the mux
- sel_valid  out  1  sel_mux and nb* meaningful this cycle
- sel_last  out  1  high with sel_mux = 7

## Operation
- States: IDLE (pix_ready = 1) and SCAN (pix_ready = 0).
- Counters: col (0..IMG_WIDTH-1, wraps to 0); row (2-bit, saturates at 2, incremented on col wrap).
- Accept with pix_sof = 1: pixel is treated as row 0, col 0 and counters restart from there, regardless of prior state.
- Line buffers lb0 (previous row) and lb1 (two rows up): IMG_WIDTH x 8 each, combinational read, not reset.
- Per accept at column c, the new column is top = lb1[c], mid = lb0[c], bot = pix_in.
  - Write back: lb1[c] <= lb0[c], lb0[c] <= pix_in.
  - Column shift registers c0 (oldest) <= c1, c1 <= new column, for each of the three rows.
- Window complete when the accepted pixel has row = 2 and col >= 2. On that accept edge, the output registers load:
  - nb1 = top.c0, nb2 = top.c1, nb3 = top.new
  - nb4 = mid.c0, center = mid.c1, nb5 = mid.new
  - nb6 = bot.c0, nb7 = bot.c1, nb8 = bot.new
  - State goes to SCAN with sel_mux = 0.
- Pixels that do not complete a window (rows 0-1, cols 0-1): absorbed into the buffers; state stays IDLE; nb*/center hold their values.
- No edge padding: border pixels produce no window.
- SCAN: sel_valid = 1. sel_mux increments by 1 each cycle. When sel_mux = 7, sel_last = 1 and the next edge returns to IDLE with sel_valid = 0.
- nb* and center are stable for the whole SCAN.

## Timing
- Reset values: pix_ready = 1, sel_valid = 0, sel_last = 0, sel_mux = 0, nb1..nb8 = 0, center = 0, state IDLE, col = 0, row = 0.
- Window-completing accept at edge k:
  - Cycles k+1..k+8: sel_valid = 1, sel_mux = 0..7; sel_last only in cycle k+8.
  - pix_ready is low in the same cycles and high again after edge k+8.
- Throughput:
  - Windowed pixels: one accepted per 9 cycles.
  - Border pixels: one per cycle.
- pix_valid while pix_ready = 0: ignored, no state change; upstream must hold the pixel.
- rst asserted mid-SCAN: next edge forces all reset values and drops sel_valid immediately. Line-buffer contents become don't-care, because row = 0 gates window validity.
- Column wrap: on the accept at col = IMG_WIDTH-1, col becomes 0 and row increments (saturating). The column shift registers carry across the wrap, but no window forms until col >= 2 again.

## Test plan
- Reset, then check outputs: rst high 2 cycles -> pix_ready = 1, sel_valid = 0, sel_mux = 0, all nb*/center = 0.
- First window, IMG_WIDTH = 4: feed ramp pixel = row*16+col with pix_sof on the first pixel, pix_valid held high. The accept of 0x22 gives:
  - nb1..nb8 = 00,01,02,10,12,20,21,22 and center = 11;
  - sel_mux 0..7 over the next 8 cycles, sel_last with 7;
  - pix_ready low for exactly those 8 cycles.
- Full frame, IMG_WIDTH = 4, 4 rows: exactly 4 windows, centres 0x11, 0x12, 0x21, 0x22. No window for pixels at col 0-1 after the row wrap.
- Backpressure: pix_valid held high with changing pix_in during SCAN -> no pixel consumed; the next accepted value is the one present when pix_ready rises.
- Reset mid-SCAN at sel_mux = 3 -> next cycle sel_valid = 0, pix_ready = 1. Re-feeding rows 0-1 produces no window until a row-2 pixel with col >= 2.
- Mid-frame pix_sof: counters restart. Windows resume only at the third row after the sof, with values from the new frame.
